// File: rtl/alu_seq_if.sv
// Operand-issue / writeback handshake bundle for alu_seq.
// The slave modport is the ALU side.
interface alu_seq_if #(
    parameter int unsigned N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] y;
    logic [N-1:0] y_hi;
    logic         carry;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic         err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, y_hi, carry, zero, neg, ovf, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, y_hi, carry, zero, neg, ovf, err
    );
endinterface

// File: rtl/alu_seq.sv
// N-bit ALU with valid/ready on both sides, registered result and flags,
// and an optional iterative shift-add unsigned multiplier (MULU, N cycles).
module alu_seq #(
    parameter int unsigned N      = 8,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int unsigned SW = $clog2(N);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MULU = 4'd10;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t         state;
    logic [N-1:0]   y_q;
    logic [N-1:0]   y_hi_q;
    logic           carry_q;
    logic           zero_q;
    logic           neg_q;
    logic           ovf_q;
    logic           err_q;
    logic [N-1:0]   mcand;
    logic [2*N-1:0] prod;
    logic [N-1:0]   cnt;

    logic           in_ready_c;
    logic           accept_c;
    logic           is_mul_c;
    logic [SW-1:0]  sh_c;
    logic           sh_big_c;
    logic [N:0]     sum_add_c;
    logic [N:0]     sum_sub_c;
    logic [N-1:0]   r_y_c;
    logic           r_carry_c;
    logic           r_ovf_c;
    logic           r_err_c;
    logic [N:0]     hi_sum_c;
    logic [2*N-1:0] prod_next_c;

    // in_ready follows out_ready while a result is parked in HOLD
    assign in_ready_c = (state == IDLE) || ((state == HOLD) && bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;
    assign is_mul_c   = MUL_EN && (bus.op == OP_MULU);

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state == HOLD);
    assign bus.y         = y_q;
    assign bus.y_hi      = y_hi_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;

    assign sh_c      = bus.b[SW-1:0];
    assign sh_big_c  = (32'(sh_c) >= 32'(N));
    assign sum_add_c = {1'b0, bus.a} + {1'b0, bus.b};
    assign sum_sub_c = {1'b0, bus.a} + {1'b0, ~bus.b} + (N+1)'(1);

    // single-cycle result; illegal ops leave everything at zero and raise err
    always_comb begin
        r_y_c     = '0;
        r_carry_c = 1'b0;
        r_ovf_c   = 1'b0;
        r_err_c   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                r_y_c     = sum_add_c[N-1:0];
                r_carry_c = sum_add_c[N];
                r_ovf_c   = (bus.a[N-1] == bus.b[N-1]) && (sum_add_c[N-1] != bus.a[N-1]);
            end
            OP_SUB: begin
                r_y_c     = sum_sub_c[N-1:0];
                r_carry_c = sum_sub_c[N];
                r_ovf_c   = (bus.a[N-1] != bus.b[N-1]) && (sum_sub_c[N-1] != bus.a[N-1]);
            end
            OP_AND:  r_y_c = bus.a & bus.b;
            OP_OR:   r_y_c = bus.a | bus.b;
            OP_XOR:  r_y_c = bus.a ^ bus.b;
            OP_SLT:  r_y_c = N'($signed(bus.a) < $signed(bus.b));
            OP_SLTU: r_y_c = N'(bus.a < bus.b);
            OP_SLL:  r_y_c = sh_big_c ? '0 : (bus.a << sh_c);
            OP_SRL:  r_y_c = sh_big_c ? '0 : (bus.a >> sh_c);
            OP_SRA:  r_y_c = sh_big_c ? {N{bus.a[N-1]}} : N'($signed(bus.a) >>> sh_c);
            default: r_err_c = 1'b1;
        endcase
    end

    // one shift-add step: add multiplicand into the high half, shift right
    assign hi_sum_c    = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_next_c = {hi_sum_c, prod[N-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            y_q     <= '0;
            y_hi_q  <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            mcand   <= '0;
            prod    <= '0;
            cnt     <= '0;
        end else if (accept_c) begin
            if (is_mul_c) begin
                mcand <= bus.a;
                prod  <= {N'(0), bus.b};
                cnt   <= '0;
                state <= BUSY;
            end else begin
                y_q     <= r_y_c;
                y_hi_q  <= '0;
                carry_q <= r_carry_c;
                zero_q  <= (r_y_c == '0);
                neg_q   <= r_y_c[N-1];
                ovf_q   <= r_ovf_c;
                err_q   <= r_err_c;
                state   <= HOLD;
            end
        end else begin
            case (state)
                BUSY: begin
                    prod <= prod_next_c;
                    if (cnt == N'(N-1)) begin
                        cnt     <= '0;
                        y_q     <= prod_next_c[N-1:0];
                        y_hi_q  <= prod_next_c[2*N-1:N];
                        carry_q <= 1'b0;
                        zero_q  <= (prod_next_c == '0);
                        neg_q   <= prod_next_c[2*N-1];
                        ovf_q   <= (prod_next_c[2*N-1:N] != '0);
                        err_q   <= 1'b0;
                        state   <= HOLD;
                    end else begin
                        cnt <= cnt + N'(1);
                    end
                end
                HOLD: if (bus.out_ready) state <= IDLE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: one DUT with MULU, one built without it.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_seq_if #(.N(8)) bus ();
    alu_seq_if #(.N(8)) bus2 ();

    alu_seq #(.N(8), .MUL_EN(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    alu_seq #(.N(8), .MUL_EN(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.op         = '0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.a         = '0;
        bus2.b         = '0;
        bus2.op        = '0;
        bus2.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_in_ready",  32'(bus.in_ready),  32'h1);
        check("rst_y",         32'(bus.y),         32'h0);
        check("rst_err",       32'(bus.err),       32'h0);

        issue(4'd0, 8'h7F, 8'h01);
        tick();
        check("add_y",     32'(bus.y),         32'h80);
        check("add_ovf",   32'(bus.ovf),       32'h1);
        check("add_neg",   32'(bus.neg),       32'h1);
        check("add_carry", 32'(bus.carry),     32'h0);
        check("add_valid", 32'(bus.out_valid), 32'h1);

        issue(4'd1, 8'h00, 8'h01);
        tick();
        check("sub_y",     32'(bus.y),     32'hFF);
        check("sub_carry", 32'(bus.carry), 32'h0);
        check("sub_neg",   32'(bus.neg),   32'h1);
        check("sub_ovf",   32'(bus.ovf),   32'h0);

        issue(4'd0, 8'h01, 8'h01);
        tick();
        check("stream_add",  32'(bus.y), 32'h02);
        issue(4'd4, 8'hF0, 8'h0F);
        tick();
        check("stream_xor",  32'(bus.y), 32'hFF);
        issue(4'd6, 8'h01, 8'hFF);
        tick();
        check("stream_sltu", 32'(bus.y), 32'h01);
        issue(4'd9, 8'h80, 8'h03);
        tick();
        check("stream_sra",  32'(bus.y), 32'hF0);
        check("stream_valid", 32'(bus.out_valid), 32'h1);
        bus.in_valid = 1'b0;
        tick();
        check("drain_idle", 32'(bus.out_valid), 32'h0);

        issue(4'd10, 8'hFF, 8'hFF);
        tick();
        issue(4'd0, 8'h11, 8'h22);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("mul_busy_ready", 32'(bus.in_ready),  32'h0);
            check("mul_busy_valid", 32'(bus.out_valid), 32'h0);
            tick();
        end
        check("mul_valid", 32'(bus.out_valid), 32'h1);
        check("mul_prod",  32'({bus.y_hi, bus.y}), 32'hFE01);
        check("mul_ovf",   32'(bus.ovf),  32'h1);
        check("mul_zero",  32'(bus.zero), 32'h0);
        check("mul_neg",   32'(bus.neg),  32'h1);

        issue(4'd10, 8'h0D, 8'h0B);
        tick();
        bus.in_valid = 1'b0;
        repeat (8) tick();
        check("mul2_prod", 32'({bus.y_hi, bus.y}), 32'h008F);
        check("mul2_ovf",  32'(bus.ovf), 32'h0);
        tick();

        bus.out_ready = 1'b0;
        issue(4'd0, 8'h12, 8'h34);
        tick();
        issue(4'd2, 8'hF0, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            check("bp_y",     32'(bus.y),         32'h46);
            check("bp_valid", 32'(bus.out_valid), 32'h1);
            check("bp_ready", 32'(bus.in_ready),  32'h0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_ready_comb", 32'(bus.in_ready), 32'h1);
        tick();
        check("bp_new_y", 32'(bus.y), 32'h30);

        issue(4'hF, 8'h12, 8'h34);
        tick();
        check("ill_err",  32'(bus.err),  32'h1);
        check("ill_y",    32'({bus.y_hi, bus.y}), 32'h0);
        check("ill_zero", 32'(bus.zero), 32'h1);

        issue(4'd5, 8'h80, 8'h01);
        tick();
        check("slt_y", 32'(bus.y), 32'h01);
        issue(4'd7, 8'h81, 8'h09);
        tick();
        check("sll_y", 32'(bus.y), 32'h02);
        issue(4'd0, 8'hFF, 8'h01);
        tick();
        check("addc_y",     32'(bus.y),     32'h00);
        check("addc_carry", 32'(bus.carry), 32'h1);
        check("addc_zero",  32'(bus.zero),  32'h1);
        issue(4'd8, 8'h80, 8'h07);
        tick();
        check("srl_y", 32'(bus.y), 32'h01);

        issue(4'd10, 8'h03, 8'h05);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_mul_valid", 32'(bus.out_valid), 32'h0);
        check("rst_mul_ready", 32'(bus.in_ready),  32'h1);
        check("rst_mul_y",     32'(bus.y),         32'h0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("no_stray", 32'(bus.out_valid), 32'h0);
        end

        bus2.in_valid = 1'b1;
        bus2.op       = 4'd10;
        bus2.a        = 8'h03;
        bus2.b        = 8'h05;
        tick();
        bus2.in_valid = 1'b0;
        check("nomul_valid", 32'(bus2.out_valid), 32'h1);
        check("nomul_err",   32'(bus2.err),       32'h1);
        check("nomul_y",     32'({bus2.y_hi, bus2.y}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
